// File: rtl/au_encode_seq.sv
// Multi-cycle lowest-set-bit encoder: scans a 2**WIDTH vector one 2**CHUNK_LOG chunk per clock.
// Optional one-hot checking on err is enabled by defining AU_ENCODE_ONEHOT_CHK_EN.
module au_encode_seq #(
  parameter int WIDTH     = 3,
  parameter int CHUNK_LOG = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [2**WIDTH-1:0]   a,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [WIDTH-1:0]      z,
  output logic                  zero,
  output logic                  err
);

  localparam int N      = 2**WIDTH;
  localparam int CW     = 2**CHUNK_LOG;
  localparam int CNTW   = WIDTH - CHUNK_LOG;
  localparam int NC     = 2**CNTW;
  localparam int CNTW_E = (CNTW > 0) ? CNTW : 1;

  if (WIDTH < 1) begin : g_bad_width
    $fatal(1, "ERROR: %m WIDTH=%0d", WIDTH);
  end
  if (CHUNK_LOG < 0 || CHUNK_LOG > WIDTH) begin : g_bad_chunk
    $fatal(1, "ERROR: %m CHUNK_LOG=%0d", CHUNK_LOG);
  end

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  state_t              state_q, state_d;
  logic [N-1:0]        a_q, a_d;
  logic [CNTW_E-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]    z_q, z_d;
  logic                zero_q, zero_d;

  logic [CW-1:0]       chunk;
  logic                hit, last, done_ld;
  logic [WIDTH-1:0]    loc, hit_z;

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign z         = z_q;
  assign zero      = zero_q;

  // Chunk mux and in-chunk priority encoder; only this width scales with CHUNK_LOG.
  always_comb begin
    chunk = '0;
    for (int c = 0; c < NC; c++) begin
      if (cnt_q == CNTW_E'(c)) chunk = a_q[c*CW +: CW];
    end
    loc = '0;
    for (int i = CW - 1; i >= 0; i--) begin
      if (chunk[i]) loc = WIDTH'(i);
    end
    hit     = |chunk;
    last    = (cnt_q == CNTW_E'(NC - 1));
    hit_z   = (WIDTH'(cnt_q) << CHUNK_LOG) | loc;
    done_ld = (state_q == SCAN) && (hit || last);
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    cnt_d   = cnt_q;
    z_d     = z_q;
    zero_d  = zero_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = a;
          cnt_d   = '0;
          state_d = SCAN;
        end
      end
      SCAN: begin
        if (hit) begin
          z_d     = hit_z;
          zero_d  = 1'b0;
          state_d = DONE;
        end else if (last) begin
          z_d     = '0;
          zero_d  = 1'b1;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      z_q     <= '0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      z_q     <= z_d;
      zero_q  <= zero_d;
    end
  end

  // A single chunk needs no counter; chunk 0 is always the last one.
  if (CNTW > 0) begin : g_cnt
    always_ff @(posedge clk) begin
      if (!rst_n) cnt_q <= '0;
      else        cnt_q <= cnt_d;
    end
  end else begin : g_nocnt
    logic unused_cnt;
    assign cnt_q      = '0;
    assign unused_cnt = ^cnt_d;
  end

`ifdef AU_ENCODE_ONEHOT_CHK_EN
  // Multi-hot flag is taken from the raw input at acceptance, published with the result.
  logic err_pend_q, err_pend_d;
  logic err_q, err_d;

  always_comb begin
    err_pend_d = err_pend_q;
    err_d      = err_q;
    if (state_q == IDLE && in_valid) err_pend_d = |(a & (a - N'(1)));
    if (done_ld) err_d = err_pend_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err_pend_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      err_pend_q <= err_pend_d;
      err_q      <= err_d;
    end
  end

  assign err = err_q;
`else
  logic unused_done;
  assign unused_done = done_ld;
  assign err         = 1'b0;
`endif

endmodule

// File: tb/tb_au_encode_seq.sv
// Self-checking bench for au_encode_seq: directed cases on a WIDTH=4/CHUNK_LOG=2 instance,
// plus a randomized parameter sweep checked against a lowest-set-bit reference model.
module tb_au_encode_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

`ifdef AU_ENCODE_ONEHOT_CHK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  // Main directed instance
  logic        rst_n, in_valid, in_ready, out_valid, out_ready, zero, err;
  logic [15:0] a;
  logic [3:0]  z;

  au_encode_seq #(.WIDTH(4), .CHUNK_LOG(2)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .a(a),
    .out_valid(out_valid), .out_ready(out_ready), .z(z), .zero(zero), .err(err)
  );

  // Sweep instances: WIDTH 1..5, CHUNK_LOG in {0, WIDTH/2, WIDTH}
  localparam int NI = 15;
  logic                   sw_rst_n, sw_iv, sw_or;
  logic [NI-1:0]          sw_ir, sw_ov, sw_zero, sw_err;
  logic [NI-1:0][31:0]    sw_a;
  logic [NI-1:0][4:0]     sw_z;

  for (genvar gw = 1; gw <= 5; gw++) begin : g_w
    for (genvar gc = 0; gc < 3; gc++) begin : g_c
      localparam int CL = (gc == 0) ? 0 : (gc == 1) ? gw / 2 : gw;
      localparam int IX = (gw - 1) * 3 + gc;
      logic [gw-1:0] zl;
      au_encode_seq #(.WIDTH(gw), .CHUNK_LOG(CL)) u (
        .clk(clk), .rst_n(sw_rst_n), .in_valid(sw_iv), .in_ready(sw_ir[IX]),
        .a(sw_a[IX][(1<<gw)-1:0]), .out_valid(sw_ov[IX]), .out_ready(sw_or),
        .z(zl), .zero(sw_zero[IX]), .err(sw_err[IX])
      );
      assign sw_z[IX] = 5'(zl);
    end
  end

  function automatic int sw_w(int i);
    return i / 3 + 1;
  endfunction

  function automatic int sw_cl(int i);
    int w = i / 3 + 1;
    case (i % 3)
      0:       return 0;
      1:       return w / 2;
      default: return w;
    endcase
  endfunction

  // Reference model: plain scan of the vector, chunk index derived arithmetically.
  function automatic logic [31:0] lowmask(int n);
    logic [31:0] m;
    m = (n >= 32) ? 32'hFFFF_FFFF : ((32'd1 << n) - 32'd1);
    return m;
  endfunction

  function automatic int low_idx(logic [31:0] v, int n);
    for (int i = 0; i < n; i++) if (v[i]) return i;
    return -1;
  endfunction

  function automatic int exp_lat(logic [31:0] v, int w, int cl);
    int li = low_idx(v, 1 << w);
    if (li < 0) return 1 << (w - cl);
    return (li >> cl) + 1;
  endfunction

  function automatic bit exp_err(logic [31:0] v, int n);
    return CHK && ($countones(v & lowmask(n)) > 1);
  endfunction

  // Drives one vector through the main DUT; reports latency (-1 on timeout) and result.
  task automatic send(input logic [15:0] v, output int lat, output logic [3:0] zz,
                      output logic zr, output logic er);
    a = v; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; lat = 0;
    while (!out_valid && lat < 20) begin @(posedge clk); #1; lat++; end
    if (!out_valid) lat = -1;
    zz = z; zr = zero; er = err;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; a = '0;
    sw_rst_n = 1'b0; sw_iv = 1'b0; sw_or = 1'b0; sw_a = '0;
    @(posedge clk); #1;
    n_cmp++; if (in_ready !== 1'b1)  begin n_bad++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    n_cmp++; if (z !== 4'd0)         begin n_bad++; $display("FAIL reset_z got %0d want 0", z); end
    n_cmp++; if (zero !== 1'b0)      begin n_bad++; $display("FAIL reset_zero got %b want 0", zero); end
    n_cmp++; if (err !== 1'b0)       begin n_bad++; $display("FAIL reset_err got %b want 0", err); end
    n_cmp++; if (sw_ir !== '1)       begin n_bad++; $display("FAIL reset_sw_in_ready got %h want all 1", sw_ir); end
    rst_n = 1'b1; sw_rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_directed();
    logic [15:0] vv [3] = '{16'h0020, 16'h0000, 16'h8001};
    int          ez [3] = '{5, 0, 0};
    bit          ezr[3] = '{1'b0, 1'b1, 1'b0};
    int          el [3] = '{2, 4, 1};
    bit          ee [3] = '{1'b0, 1'b0, CHK};
    int lat; logic [3:0] zz; logic zr, er;
    for (int k = 0; k < 3; k++) begin
      send(vv[k], lat, zz, zr, er);
      n_cmp++; if (lat != el[k])        begin n_bad++; $display("FAIL dir%0d_latency got %0d want %0d", k, lat, el[k]); end
      n_cmp++; if (zz !== 4'(ez[k]))    begin n_bad++; $display("FAIL dir%0d_z got %0d want %0d", k, zz, ez[k]); end
      n_cmp++; if (zr !== ezr[k])       begin n_bad++; $display("FAIL dir%0d_zero got %b want %b", k, zr, ezr[k]); end
      n_cmp++; if (er !== ee[k])        begin n_bad++; $display("FAIL dir%0d_err got %b want %b", k, er, ee[k]); end
    end
  endtask

  task automatic test_random_main();
    int lat, li; logic [3:0] zz; logic zr, er; logic [15:0] v;
    for (int k = 0; k < 30; k++) begin
      v = 16'($urandom) & 16'($urandom) & 16'($urandom);
      if (k % 7 == 0) v = '0;
      li = low_idx(32'(v), 16);
      send(v, lat, zz, zr, er);
      n_cmp++; if (lat != exp_lat(32'(v), 4, 2)) begin n_bad++; $display("FAIL rnd_latency a=%h got %0d want %0d", v, lat, exp_lat(32'(v), 4, 2)); end
      n_cmp++; if (zz !== 4'((li < 0) ? 0 : li)) begin n_bad++; $display("FAIL rnd_z a=%h got %0d want %0d", v, zz, li); end
      n_cmp++; if (zr !== (li < 0))              begin n_bad++; $display("FAIL rnd_zero a=%h got %b want %b", v, zr, li < 0); end
      n_cmp++; if (er !== exp_err(32'(v), 16))   begin n_bad++; $display("FAIL rnd_err a=%h got %b want %b", v, er, exp_err(32'(v), 16)); end
    end
  endtask

  task automatic test_backpressure();
    int lat;
    a = 16'h0100; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; lat = 0;
    while (!out_valid && lat < 20) begin @(posedge clk); #1; lat++; end
    n_cmp++; if (lat != 3) begin n_bad++; $display("FAIL bp_latency got %0d want 3", lat); end
    for (int k = 0; k < 5; k++) begin
      in_valid = 1'b1; a = 16'($urandom) | 16'h0001; out_ready = 1'b0;
      @(posedge clk); #1;
      n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL bp_hold_valid cyc%0d got %b want 1", k, out_valid); end
      n_cmp++; if (in_ready !== 1'b0)  begin n_bad++; $display("FAIL bp_in_ready cyc%0d got %b want 0", k, in_ready); end
      n_cmp++; if (z !== 4'd8)         begin n_bad++; $display("FAIL bp_z cyc%0d got %0d want 8", k, z); end
      n_cmp++; if (zero !== 1'b0)      begin n_bad++; $display("FAIL bp_zero cyc%0d got %b want 0", k, zero); end
      n_cmp++; if (err !== 1'b0)       begin n_bad++; $display("FAIL bp_err cyc%0d got %b want 0", k, err); end
    end
    out_ready = 1'b1; a = 16'h0004; in_valid = 1'b1;
    @(posedge clk); #1;
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL bp_idle_valid got %b want 0", out_valid); end
    n_cmp++; if (in_ready !== 1'b1)  begin n_bad++; $display("FAIL bp_idle_ready got %b want 1", in_ready); end
    out_ready = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0; lat = 0;
    while (!out_valid && lat < 20) begin @(posedge clk); #1; lat++; end
    n_cmp++; if (lat != 1)     begin n_bad++; $display("FAIL bp_next_latency got %0d want 1", lat); end
    n_cmp++; if (z !== 4'd2)   begin n_bad++; $display("FAIL bp_next_z got %0d want 2", z); end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset_mid_scan();
    a = 16'h8000; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL rst_scan_valid got %b want 0", out_valid); end
    n_cmp++; if (in_ready !== 1'b1)  begin n_bad++; $display("FAIL rst_scan_ready got %b want 1", in_ready); end
    n_cmp++; if (z !== 4'd0)         begin n_bad++; $display("FAIL rst_scan_z got %0d want 0", z); end
    rst_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL rst_scan_stale cyc%0d got %b want 0", k, out_valid); end
    end
  endtask

  task automatic test_sweep();
    logic [NI-1:0] seen;
    int cyc, n, li, el;
    logic [31:0] v;
    for (int r = 0; r < 72; r++) begin
      for (int i = 0; i < NI; i++) begin
        n = 1 << sw_w(i);
        if (r < 32) v = 32'd1 << (r % n);
        else begin
          v = $urandom & $urandom;
          if (r % 8 == 0) v = '0;
        end
        sw_a[i] = v;
      end
      sw_iv = 1'b1;
      @(posedge clk); #1;
      sw_iv = 1'b0; seen = '0; cyc = 0;
      while (!(seen == '1 && sw_ir == '1) && cyc < 80) begin
        @(posedge clk); #1;
        cyc++;
        for (int i = 0; i < NI; i++) begin
          if (!seen[i] && sw_ov[i]) begin
            seen[i] = 1'b1;
            n  = 1 << sw_w(i);
            li = low_idx(sw_a[i], n);
            el = exp_lat(sw_a[i], sw_w(i), sw_cl(i));
            n_cmp++; if (cyc != el) begin n_bad++; $display("FAIL sw_latency w=%0d cl=%0d a=%h got %0d want %0d", sw_w(i), sw_cl(i), sw_a[i] & lowmask(n), cyc, el); end
            n_cmp++; if (sw_z[i] !== 5'((li < 0) ? 0 : li)) begin n_bad++; $display("FAIL sw_z w=%0d cl=%0d a=%h got %0d want %0d", sw_w(i), sw_cl(i), sw_a[i] & lowmask(n), sw_z[i], li); end
            n_cmp++; if (sw_zero[i] !== (li < 0)) begin n_bad++; $display("FAIL sw_zero w=%0d cl=%0d got %b want %b", sw_w(i), sw_cl(i), sw_zero[i], li < 0); end
            n_cmp++; if (sw_err[i] !== exp_err(sw_a[i], n)) begin n_bad++; $display("FAIL sw_err w=%0d cl=%0d got %b want %b", sw_w(i), sw_cl(i), sw_err[i], exp_err(sw_a[i], n)); end
          end
        end
        sw_or = 1'($urandom_range(0, 1));
      end
      sw_or = 1'b0;
      n_cmp++; if (cyc >= 80) begin n_bad++; $display("FAIL sw_timeout round %0d seen %h got timeout want completion", r, seen); end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random_main();
    test_backpressure();
    test_reset_mid_scan();
    test_sweep();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
